// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ID/EX issue stage: RV32I opcodes, ALU control
// codes ({funct7[5], funct3}) and the immediate format selector.
// Imported by alu_issue_stage and imm_gen.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

endpackage

// File: rtl/alu_issue_stage_imm_gen.sv
// Immediate generator: extracts the sign-extended immediate of the selected format.
// Latency: combinational (0 cycles).
// Backpressure: none, pure function of its inputs.
// Ports: instr (raw instruction), fmt (immediate format), imm (32-bit result).
module imm_gen
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // Opcode bits never carry immediate payload.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    unique case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I, selects ALU operands/control, registers them for execute.
// Latency: 1 cycle from accepted input to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; held entry is bit-stable while !out_ready.
// Ports: clock/reset_n (async active-low); in_* decode-side handshake and operands;
//   flush kills the held entry and drops the input; out_* registered execute-side entry.
// Optional: define ALU_ISSUE_PERF_EN to add perf_issued / perf_stall counters.
// Only DATA_W = 32 is supported.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [CTRL_W-1:0] out_control,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_rs2_data,
  output logic              out_illegal,
  output logic [DATA_W-1:0] out_pc
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall
`endif
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  imm_fmt_t          imm_fmt;
  logic [DATA_W-1:0] imm_raw;
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [DATA_W-1:0] dec_imm;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              load;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  imm_gen u_imm_gen (
    .instr (in_instr),
    .fmt   (imm_fmt),
    .imm   (imm_raw)
  );

  always_comb begin
    imm_fmt     = IMM_NONE;
    dec_a       = '0;
    dec_b       = '0;
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec_a    = in_rs1_data;
        dec_b    = in_rs2_data;
        dec_ctrl = {in_instr[30], funct3};
      end
      OPC_OPIMM: begin
        imm_fmt  = IMM_I;
        dec_a    = in_rs1_data;
        // Shifts take only the 5-bit shamt; instr[30] lives in the same
        // field and would otherwise pollute the shift amount.
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          dec_b = {27'b0, in_instr[24:20]};
        end else begin
          dec_b = imm_raw;
        end
        // instr[30] selects SRA only; ADDI with imm[10]=1 must stay an add.
        dec_ctrl = {(funct3 == F3_SRX) ? in_instr[30] : 1'b0, funct3};
      end
      OPC_LOAD: begin
        imm_fmt = IMM_I;
        dec_a   = in_rs1_data;
        dec_b   = imm_raw;
      end
      OPC_STORE: begin
        imm_fmt = IMM_S;
        dec_a   = in_rs1_data;
        dec_b   = imm_raw;
      end
      OPC_BRANCH: begin
        imm_fmt  = IMM_B;
        dec_a    = in_rs1_data;
        dec_b    = in_rs2_data;
        dec_ctrl = ALU_SUB;
      end
      OPC_LUI: begin
        imm_fmt = IMM_U;
        dec_b   = imm_raw;
      end
      OPC_AUIPC: begin
        imm_fmt = IMM_U;
        dec_a   = in_pc;
        dec_b   = imm_raw;
      end
      OPC_JAL: begin
        // ALU produces the link value pc+4; the target uses out_imm.
        imm_fmt = IMM_J;
        dec_a   = in_pc;
        dec_b   = 32'd4;
      end
      OPC_JALR: begin
        imm_fmt = IMM_I;
        dec_a   = in_pc;
        dec_b   = 32'd4;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // imm_gen already returns zero for IMM_NONE (R-type and illegal).
  assign dec_imm = imm_raw;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_control  <= '0;
      out_imm      <= '0;
      out_rs2_data <= '0;
      out_illegal  <= 1'b0;
      out_pc       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid    <= 1'b1;
      out_a        <= dec_a;
      out_b        <= dec_b;
      out_control  <= dec_ctrl;
      out_imm      <= dec_imm;
      out_rs2_data <= in_rs2_data;
      out_illegal  <= dec_illegal;
      out_pc       <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (load) begin
        perf_issued <= perf_issued + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, backpressure, flush,
// asynchronous reset during hold, and (when ALU_ISSUE_PERF_EN) the perf counters.
module tb_alu_issue_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_control;
  logic [31:0] out_imm;
  logic [31:0] out_rs2_data;
  logic        out_illegal;
  logic [31:0] out_pc;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int total = 0;
  int fails = 0;
  int n_loads = 0;

  alu_issue_stage dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_control  (out_control),
    .out_imm      (out_imm),
    .out_rs2_data (out_rs2_data),
    .out_illegal  (out_illegal),
    .out_pc       (out_pc)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued  (perf_issued),
    .perf_stall   (perf_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one instruction for one cycle; caller guarantees in_ready.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    step();
    in_valid = 1'b0;
    n_loads++;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] ctrl, input logic [31:0] imm, input logic ill);
    chk({tag, ".valid"},   32'(out_valid), 32'd1);
    chk({tag, ".a"},       out_a, a);
    chk({tag, ".b"},       out_b, b);
    chk({tag, ".ctrl"},    32'(out_control), 32'(ctrl));
    chk({tag, ".imm"},     out_imm, imm);
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_pc       = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    #12;
    chk("rst.valid",    32'(out_valid), 32'd0);
    chk("rst.ctrl",     32'(out_control), 32'd0);
    chk("rst.a",        out_a, 32'd0);
    chk("rst.illegal",  32'(out_illegal), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Decode vectors with execute always ready.
    out_ready = 1'b1;
    issue(32'h002081B3, 32'h0000_1000, 32'd5, 32'd7);                 // add
    chk_entry("add", 32'd5, 32'd7, 4'b0000, 32'd0, 1'b0);
    chk("add.pc", out_pc, 32'h0000_1000);
    issue(32'h402081B3, 32'h0000_1004, 32'd5, 32'd7);                 // sub
    chk_entry("sub", 32'd5, 32'd7, 4'b1000, 32'd0, 1'b0);
    issue(32'h40315093, 32'h0000_1008, 32'h8000_0000, 32'd0);         // srai
    chk_entry("srai", 32'h8000_0000, 32'd3, 4'b1101, 32'h0000_0403, 1'b0);
    issue(32'h40000093, 32'h0000_100C, 32'd0, 32'd0);                 // addi 0x400
    chk_entry("addi400", 32'd0, 32'h0000_0400, 4'b0000, 32'h0000_0400, 1'b0);
    issue(32'hFFF00093, 32'h0000_1010, 32'd0, 32'd0);                 // addi -1
    chk_entry("addim1", 32'd0, 32'hFFFF_FFFF, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    issue(32'h0020A423, 32'h0000_1014, 32'h0000_2000, 32'hCAFE_F00D); // sw x2,8(x1)
    chk_entry("sw", 32'h0000_2000, 32'd8, 4'b0000, 32'd8, 1'b0);
    chk("sw.rs2", out_rs2_data, 32'hCAFE_F00D);
    issue(32'h00208463, 32'h0000_1018, 32'd11, 32'd12);               // beq +8
    chk_entry("beq", 32'd11, 32'd12, 4'b1000, 32'd8, 1'b0);
    issue(32'h123450B7, 32'h0000_101C, 32'd99, 32'd0);                // lui
    chk_entry("lui", 32'd0, 32'h1234_5000, 4'b0000, 32'h1234_5000, 1'b0);
    issue(32'h00001097, 32'h0000_0200, 32'd0, 32'd0);                 // auipc 1
    chk_entry("auipc", 32'h0000_0200, 32'h0000_1000, 4'b0000, 32'h0000_1000, 1'b0);
    issue(32'h010000EF, 32'h0000_0100, 32'd0, 32'd0);                 // jal +16
    chk_entry("jal", 32'h0000_0100, 32'd4, 4'b0000, 32'h0000_0010, 1'b0);
    issue(32'hFFDFF06F, 32'h0000_0104, 32'd0, 32'd0);                 // jal -4
    chk_entry("jalneg", 32'h0000_0104, 32'd4, 4'b0000, 32'hFFFF_FFFC, 1'b0);
    issue(32'h000080E7, 32'h0000_0300, 32'h0000_4000, 32'd0);         // jalr
    chk_entry("jalr", 32'h0000_0300, 32'd4, 4'b0000, 32'd0, 1'b0);
    issue(32'h0000007F, 32'h0000_0400, 32'd1, 32'd2);                 // illegal
    chk_entry("illegal", 32'd0, 32'd0, 4'b0000, 32'd0, 1'b1);
    step();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // Backpressure: held entry stable, in_ready low, no bubble on release.
    out_ready = 1'b0;
    issue(32'h002081B3, 32'h0000_2000, 32'd21, 32'd22);
    in_valid    = 1'b1;
    in_instr    = 32'h402081B3;
    in_pc       = 32'h0000_2004;
    in_rs1_data = 32'd9;
    in_rs2_data = 32'd4;
    for (int i = 0; i < 3; i++) begin
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.valid",    32'(out_valid), 32'd1);
      chk("hold.a",        out_a, 32'd21);
      chk("hold.ctrl",     32'(out_control), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", 32'(in_ready), 32'd1);
    step();
    n_loads++;
    in_valid = 1'b0;
    chk_entry("release", 32'd9, 32'd4, 4'b1000, 32'd0, 1'b0);
    chk("release.pc", out_pc, 32'h0000_2004);
    step();
    chk("nodup.valid", 32'(out_valid), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("perf.issued", perf_issued, 32'(n_loads));
    chk("perf.stall",  perf_stall, 32'd3);
`endif

    // Flush beats a simultaneous load and drain.
    issue(32'h002081B3, 32'h0000_3000, 32'd1, 32'd1);
    chk("preflush.valid", 32'(out_valid), 32'd1);
    flush       = 1'b1;
    in_valid    = 1'b1;
    in_instr    = 32'h402081B3;
    in_rs1_data = 32'h55;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush.valid", 32'(out_valid), 32'd0);
    step();
    chk("flush.noissue", 32'(out_valid), 32'd0);

    // Asynchronous reset while holding an entry.
    out_ready = 1'b0;
    issue(32'h402081B3, 32'h0000_4000, 32'd77, 32'd1);
    step();
    chk("prerst.valid", 32'(out_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.a",     out_a, 32'd0);
    chk("arst.ctrl",  32'(out_control), 32'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    issue(32'h123450B7, 32'h0000_5000, 32'd0, 32'd0);
    chk_entry("postrst", 32'd0, 32'h1234_5000, 4'b0000, 32'h1234_5000, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
